// File: rtl/bscalc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bscalc_pkg
// Purpose : Shared definitions for the Black-Scholes calculation blocks.
//           Q16.16 constants, saturating negation and the norm_sched state
//           encoding.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package bscalc_pkg;

  localparam int DATA_W = 32;

  // Q16.16 fixed-point constants
  localparam logic [DATA_W-1:0] ONE  = 32'h0001_0000;
  localparam logic [DATA_W-1:0] HALF = 32'h0000_8000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Two's-complement negation; the most negative value has no positive
  // counterpart, so it clamps to the most positive value instead of wrapping.
  function automatic logic [DATA_W-1:0] sat_neg(input logic [DATA_W-1:0] x);
    if (x == {1'b1, {(DATA_W-1){1'b0}}})
      sat_neg = {1'b0, {(DATA_W-1){1'b1}}};
    else
      sat_neg = -x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/norm_sched.sv
`default_nettype none
// ============================================================================
// Module  : norm_sched
// Purpose : Shares one cumulative-normal evaluator across the four values of
//           a Black-Scholes job: N(d1), N(d2), N(-d1), N(-d2). Accepts a
//           (d1, d2) job, issues evaluations one at a time, and returns all
//           four results in one response beat. With USE_SYMMETRY only d1 and
//           d2 are evaluated and N(-x) = ONE - N(x) is derived.
// Ports   : clk, reset (async, active-high)
//           in_valid/in_ready/in_d1/in_d2           - job request
//           out_valid/out_ready/out_nd1/out_nd2/
//           out_nd1n/out_nd2n/out_err               - job response
//           norm_start/norm_d/norm_N/norm_done      - evaluator handshake
// Revision: 1.0 - initial release
// ============================================================================
module norm_sched
  import bscalc_pkg::*;
#(
  parameter int WIDTH          = DATA_W,
  parameter bit USE_SYMMETRY   = 1'b1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_d1,
  input  logic [WIDTH-1:0] in_d2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_nd1,
  output logic [WIDTH-1:0] out_nd2,
  output logic [WIDTH-1:0] out_nd1n,
  output logic [WIDTH-1:0] out_nd2n,
  output logic             out_err,
  output logic             norm_start,
  output logic [WIDTH-1:0] norm_d,
  input  logic [WIDTH-1:0] norm_N,
  input  logic             norm_done
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  // Slot index of the final evaluation: 1 when -d1/-d2 are derived, else 3.
  localparam logic [1:0]       LAST_IDX = USE_SYMMETRY ? 2'd1 : 2'd3;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] d1_lat;
  logic [WIDTH-1:0] d2_lat;
  logic [1:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic             err;
  logic [WIDTH-1:0] op_sel;
  // Result slots: 0 = N(d1), 1 = N(d2), 2 = N(-d1), 3 = N(-d2)
  logic [WIDTH-1:0] slot [4];

  // Operand order is d1, d2, -d1, -d2; idx doubles as the result slot.
  always_comb begin
    op_sel = '0;
    case (idx)
      2'd0:    op_sel = d1_lat;
      2'd1:    op_sel = d2_lat;
      2'd2:    op_sel = WIDTH'(sat_neg(DATA_W'(d1_lat)));
      default: op_sel = WIDTH'(sat_neg(DATA_W'(d2_lat)));
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    norm_start = 1'b0;
    norm_d     = '0;
    case (state)
      ST_IDLE: begin
        // Keep ready low while reset is held so no job is taken mid-reset.
        in_ready = ~reset;
        if (in_valid) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        norm_start = 1'b1;
        norm_d     = op_sel;
        state_nxt  = ST_WAIT;
      end
      ST_WAIT: begin
        norm_d = op_sel;
        // A done on the timeout cycle takes priority over the abort.
        if (norm_done)
          state_nxt = (idx == LAST_IDX) ? ST_RESP : ST_ISSUE;
        else if (cnt == CNT_MAX)
          state_nxt = ST_RESP;
      end
      ST_RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d1_lat <= '0;
      d2_lat <= '0;
      idx    <= '0;
      cnt    <= '0;
      err    <= 1'b0;
      for (int i = 0; i < 4; i++) slot[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            d1_lat <= in_d1;
            d2_lat <= in_d2;
            idx    <= '0;
            err    <= 1'b0;
            for (int i = 0; i < 4; i++) slot[i] <= '0;
          end
        end
        ST_ISSUE: cnt <= '0;
        ST_WAIT: begin
          if (norm_done) begin
            slot[idx] <= norm_N;
            // N in [0, ONE], so the complement never underflows.
            if (USE_SYMMETRY) slot[idx + 2'd2] <= WIDTH'(ONE) - norm_N;
            if (idx != LAST_IDX) idx <= idx + 2'd1;
          end else if (cnt == CNT_MAX) begin
            err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_nd1  = slot[0];
  assign out_nd2  = slot[1];
  assign out_nd1n = slot[2];
  assign out_nd2n = slot[3];
  assign out_err  = err;

endmodule
`default_nettype wire

// File: tb/tb_norm_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_norm_sched
// Purpose : Directed self-checking bench for norm_sched. Two instances are
//           exercised: one deriving N(-x) by symmetry, one evaluating all
//           four operands. Each has a behavioral evaluator with latency
//           3 cycles (x = 0 or |x| >= 5) or 7 cycles (otherwise).
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_norm_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // symmetry instance
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_err;
  logic        s_norm_start;
  logic        s_norm_done = 1'b0;
  logic [31:0] s_in_d1, s_in_d2, s_out_nd1, s_out_nd2, s_out_nd1n, s_out_nd2n;
  logic [31:0] s_norm_d;
  logic [31:0] s_norm_N = '0;

  // four-evaluation instance
  logic        f_in_valid, f_in_ready, f_out_valid, f_out_ready, f_out_err;
  logic        f_norm_start;
  logic        f_norm_done = 1'b0;
  logic [31:0] f_in_d1, f_in_d2, f_out_nd1, f_out_nd2, f_out_nd1n, f_out_nd2n;
  logic [31:0] f_norm_d;
  logic [31:0] f_norm_N = '0;

  norm_sched #(.WIDTH(32), .USE_SYMMETRY(1'b1), .TIMEOUT_CYCLES(64)) dut_s (
    .clk(clk), .reset(reset),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_d1(s_in_d1), .in_d2(s_in_d2),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_nd1(s_out_nd1), .out_nd2(s_out_nd2), .out_nd1n(s_out_nd1n), .out_nd2n(s_out_nd2n),
    .out_err(s_out_err),
    .norm_start(s_norm_start), .norm_d(s_norm_d), .norm_N(s_norm_N), .norm_done(s_norm_done)
  );

  norm_sched #(.WIDTH(32), .USE_SYMMETRY(1'b0), .TIMEOUT_CYCLES(64)) dut_f (
    .clk(clk), .reset(reset),
    .in_valid(f_in_valid), .in_ready(f_in_ready), .in_d1(f_in_d1), .in_d2(f_in_d2),
    .out_valid(f_out_valid), .out_ready(f_out_ready),
    .out_nd1(f_out_nd1), .out_nd2(f_out_nd2), .out_nd1n(f_out_nd1n), .out_nd2n(f_out_nd2n),
    .out_err(f_out_err),
    .norm_start(f_norm_start), .norm_d(f_norm_d), .norm_N(f_norm_N), .norm_done(f_norm_done)
  );

  // ---------------- evaluator model ----------------
  function automatic logic [31:0] model_n(input logic [31:0] x);
    if (x == 32'h0)                                 return 32'h0000_8000;
    else if ($signed(x) >= $signed(32'h0005_0000))  return 32'h0001_0000;
    else if ($signed(x) <= $signed(32'hFFFB_0000))  return 32'h0000_0000;
    else if (x == 32'h0001_0000)                    return 32'h0000_D762;
    else if (x == 32'hFFFF_0000)                    return 32'h0000_289E;
    else                                            return 32'h0000_1234;
  endfunction

  function automatic int model_lat(input logic [31:0] x);
    if (x == 32'h0 || $signed(x) >= $signed(32'h0005_0000) ||
        $signed(x) <= $signed(32'hFFFB_0000))
      return 3;
    return 7;
  endfunction

  logic        s_busy = 1'b0, s_hang = 1'b0;
  int          s_rem = 0, s_starts = 0;
  logic [31:0] s_res = '0;

  always @(posedge clk) begin
    s_norm_done <= 1'b0;
    if (s_norm_start) s_starts <= s_starts + 1;
    if (s_busy) begin
      if (s_rem == 1) begin
        s_norm_done <= 1'b1;
        s_norm_N    <= s_res;
        s_busy      <= 1'b0;
      end
      s_rem <= s_rem - 1;
    end else if (s_norm_start && !s_hang) begin
      s_busy <= 1'b1;
      s_rem  <= model_lat(s_norm_d) - 1;
      s_res  <= model_n(s_norm_d);
    end
  end

  logic        f_busy = 1'b0;
  int          f_rem = 0, f_starts = 0;
  logic [31:0] f_res = '0;
  logic [31:0] f_ops [8];

  always @(posedge clk) begin
    f_norm_done <= 1'b0;
    if (f_norm_start) begin
      f_starts <= f_starts + 1;
      if (f_starts < 8) f_ops[f_starts] <= f_norm_d;
    end
    if (f_busy) begin
      if (f_rem == 1) begin
        f_norm_done <= 1'b1;
        f_norm_N    <= f_res;
        f_busy      <= 1'b0;
      end
      f_rem <= f_rem - 1;
    end else if (f_norm_start) begin
      f_busy <= 1'b1;
      f_rem  <= model_lat(f_norm_d) - 1;
      f_res  <= model_n(f_norm_d);
    end
  end

  // ---------------- checking helpers ----------------
  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a job; returns the cycle (0 = accept cycle) in which out_valid was
  // first seen (-1 if never) and the number of start pulses during the job.
  task automatic job_s(input logic [31:0] d1, input logic [31:0] d2,
                       output int vcyc, output int nst);
    int st0;
    st0        = s_starts;
    s_in_d1    = d1;
    s_in_d2    = d2;
    s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0;
    vcyc       = -1;
    for (int n = 0; n < 200; n++) begin
      if (s_out_valid) begin
        vcyc = n + 1;
        break;
      end
      tick();
    end
    nst = s_starts - st0;
  endtask

  task automatic job_f(input logic [31:0] d1, input logic [31:0] d2,
                       output int vcyc, output int nst);
    int st0;
    st0        = f_starts;
    f_in_d1    = d1;
    f_in_d2    = d2;
    f_in_valid = 1'b1;
    tick();
    f_in_valid = 1'b0;
    vcyc       = -1;
    for (int n = 0; n < 200; n++) begin
      if (f_out_valid) begin
        vcyc = n + 1;
        break;
      end
      tick();
    end
    nst = f_starts - st0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int vc, ns;
    reset       = 1'b1;
    s_in_valid  = 1'b0; s_in_d1 = '0; s_in_d2 = '0; s_out_ready = 1'b1;
    f_in_valid  = 1'b0; f_in_d1 = '0; f_in_d2 = '0; f_out_ready = 1'b1;
    tick();
    tick();

    // reset values
    chk("rst_in_ready",   32'(s_in_ready),   32'd0);
    chk("rst_out_valid",  32'(s_out_valid),  32'd0);
    chk("rst_out_err",    32'(s_out_err),    32'd0);
    chk("rst_norm_start", 32'(s_norm_start), 32'd0);
    chk("rst_norm_d",     s_norm_d,          32'h0);
    chk("rst_nd1",        s_out_nd1,         32'h0);
    chk("rst_nd2n",       s_out_nd2n,        32'h0);
    chk("rst_f_in_ready", 32'(f_in_ready),   32'd0);
    reset = 1'b0;
    tick();
    chk("idle_in_ready",   32'(s_in_ready), 32'd1);
    chk("idle_f_in_ready", 32'(f_in_ready), 32'd1);

    // zero operands, L=3: both halves at 0.5
    job_s(32'h0, 32'h0, vc, ns);
    chk("zero_vcycle", 32'(vc), 32'd9);
    chk("zero_starts", 32'(ns), 32'd2);
    chk("zero_nd1",  s_out_nd1,  32'h0000_8000);
    chk("zero_nd2",  s_out_nd2,  32'h0000_8000);
    chk("zero_nd1n", s_out_nd1n, 32'h0000_8000);
    chk("zero_nd2n", s_out_nd2n, 32'h0000_8000);
    chk("zero_err",  32'(s_out_err), 32'd0);
    tick();
    chk("zero_after_valid", 32'(s_out_valid), 32'd0);

    // saturated tails
    job_s(32'h0006_0000, 32'hFFFA_0000, vc, ns);
    chk("tail_vcycle", 32'(vc), 32'd9);
    chk("tail_nd1",  s_out_nd1,  32'h0001_0000);
    chk("tail_nd2",  s_out_nd2,  32'h0000_0000);
    chk("tail_nd1n", s_out_nd1n, 32'h0000_0000);
    chk("tail_nd2n", s_out_nd2n, 32'h0001_0000);
    chk("tail_err",  32'(s_out_err), 32'd0);
    tick();

    // evaluator never answers: abort after TIMEOUT_CYCLES
    s_hang = 1'b1;
    job_s(32'h0001_0000, 32'h0, vc, ns);
    chk("tmo_vcycle", 32'(vc), 32'd67);
    chk("tmo_starts", 32'(ns), 32'd1);
    chk("tmo_err",  32'(s_out_err), 32'd1);
    chk("tmo_nd1",  s_out_nd1,  32'h0);
    chk("tmo_nd2",  s_out_nd2,  32'h0);
    chk("tmo_nd1n", s_out_nd1n, 32'h0);
    chk("tmo_nd2n", s_out_nd2n, 32'h0);
    tick();
    s_hang = 1'b0;

    // response back-pressure
    s_out_ready = 1'b0;
    job_s(32'h0, 32'h0, vc, ns);
    chk("hold_vcycle", 32'(vc), 32'd9);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_valid", 32'(s_out_valid),  32'd1);
      chk("hold_nd1",   s_out_nd1,         32'h0000_8000);
      chk("hold_ready", 32'(s_in_ready),   32'd0);
      chk("hold_start", 32'(s_norm_start), 32'd0);
    end
    s_out_ready = 1'b1;
    tick();
    chk("rel_valid", 32'(s_out_valid), 32'd0);
    chk("rel_ready", 32'(s_in_ready),  32'd1);

    // reset while waiting; the evaluator's late done must be ignored
    s_in_d1    = 32'h0001_0000;
    s_in_d2    = 32'hFFFF_0000;
    s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    #1;
    chk("mrst_in_ready", 32'(s_in_ready),   32'd0);
    chk("mrst_valid",    32'(s_out_valid),  32'd0);
    chk("mrst_start",    32'(s_norm_start), 32'd0);
    chk("mrst_norm_d",   s_norm_d,          32'h0);
    chk("mrst_err",      32'(s_out_err),    32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("late_in_ready", 32'(s_in_ready),  32'd1);
    chk("late_valid",    32'(s_out_valid), 32'd0);
    tick();
    chk("late2_start", 32'(s_norm_start), 32'd0);
    chk("late2_valid", 32'(s_out_valid),  32'd0);
    chk("late2_ready", 32'(s_in_ready),   32'd1);
    chk("late2_nd1",   s_out_nd1,         32'h0);

    // following job, L=7
    job_s(32'h0001_0000, 32'hFFFF_0000, vc, ns);
    chk("one_vcycle", 32'(vc), 32'd17);
    chk("one_starts", 32'(ns), 32'd2);
    chk("one_nd1",  s_out_nd1,  32'h0000_D762);
    chk("one_nd2",  s_out_nd2,  32'h0000_289E);
    chk("one_nd1n", s_out_nd1n, 32'h0000_289E);
    chk("one_nd2n", s_out_nd2n, 32'h0000_D762);
    chk("one_err",  32'(s_out_err), 32'd0);
    tick();

    // four evaluations, saturating negation of the most negative d1
    job_f(32'h8000_0000, 32'h0001_0000, vc, ns);
    chk("four_vcycle", 32'(vc), 32'd25);
    chk("four_starts", 32'(ns), 32'd4);
    chk("four_op0", f_ops[0], 32'h8000_0000);
    chk("four_op1", f_ops[1], 32'h0001_0000);
    chk("four_op2", f_ops[2], 32'h7FFF_FFFF);
    chk("four_op3", f_ops[3], 32'hFFFF_0000);
    chk("four_nd1",  f_out_nd1,  32'h0000_0000);
    chk("four_nd2",  f_out_nd2,  32'h0000_D762);
    chk("four_nd1n", f_out_nd1n, 32'h0001_0000);
    chk("four_nd2n", f_out_nd2n, 32'h0000_289E);
    chk("four_err",  32'(f_out_err), 32'd0);
    tick();
    chk("four_idle", 32'(f_in_ready), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
